imem_uart_loader: RTL and testbench

- Boot-time instruction memory loader sitting directly upstream of the SoC instruction RAM.
- While load_imem is high, it consumes the byte stream from the UART receiver, assembles 32-bit little-endian words, writes them into the instruction RAM write port, and holds the CPU in reset.
- It replaces the simulation-only backdoor RAM initialisation with a synthesizable load path, usable both on the board and in the SoC bench.

---
 rtl/imem_uart_loader_pkg.sv | 35 +++
 rtl/imem_uart_loader_word_packer.sv | 102 ++++++++++
 rtl/imem_uart_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_uart_loader_pkg
//   Shared definitions for the boot-time instruction memory loader:
//   - FSM state encoding (IDLE, HDR, DATA, CHK, DONE, ERR)
//   - header length and instruction RAM capacity helpers
//   - running checksum helper used on the payload stream
// -----------------------------------------------------------------------------
package imem_uart_loader_pkg;

  // Loader FSM encoding, kept as plain constants so legacy tools accept it.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  // Number of little-endian byte-count bytes leading every frame.
  localparam int unsigned LOADER_HDR_BYTES = 32'd4;

  // Default instruction RAM word-address width and matching byte capacity.
  localparam int unsigned IMEM_ADDR_WIDTH_DEF = 32'd10;
  localparam int unsigned IMEM_BYTES_DEF      = 32'd4 << IMEM_ADDR_WIDTH_DEF;

  // Byte capacity of an instruction RAM with the given word-address width.
  function automatic logic [63:0] imem_capacity_bytes(input int unsigned addr_width);
    imem_capacity_bytes = 64'd4 << addr_width;
  endfunction

  // Running XOR checksum over the payload bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data_byte);
    chk_update = chk ^ data_byte;
  endfunction

endpackage

// File: rtl/imem_uart_loader_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
//   Packs payload bytes into 32-bit little-endian words and drives the
//   instruction RAM write port.
//   Ports:
//     clk, reset        system clock, synchronous active-high reset
//     start             clear buffer and word index (new load begins)
//     discard           drop a buffered partial word (load aborted)
//     byte_valid        a payload byte is accepted this cycle
//     byte_lane         lane (0..3) the byte belongs to
//     byte_data         payload byte
//     byte_last         byte is the final payload byte of the frame
//     imem_we           one-cycle write strobe, 1 cycle after the completing byte
//     imem_addr         word address, holds its value between writes
//     imem_wdata        word data, unfilled lanes zero, holds between writes
//     word_cnt          words written since start
// -----------------------------------------------------------------------------
module imem_word_packer
  import imem_uart_loader_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       discard,
  input  logic                       byte_valid,
  input  logic [1:0]                 byte_lane,
  input  logic [7:0]                 byte_data,
  input  logic                       byte_last,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [IMEM_ADDR_WIDTH:0]   word_cnt
);

  logic [31:0]                buf_q, buf_d;
  logic                       we_q, we_d;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  // One extra bit so the count can reach the full RAM size without wrapping.
  logic [IMEM_ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [31:0]                buf_merged;

  // Buffer with the incoming byte placed into its lane; the buffer is always
  // zero in lanes not yet filled, so OR-ing is enough.
  always_comb begin
    buf_merged = buf_q | ({24'h000000, byte_data} << {byte_lane, 3'b000});
  end

  // Next-state logic: lane fill, word flush, and buffer clear on start/discard.
  always_comb begin
    buf_d      = buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_idx_d = word_idx_q;
    if (start) begin
      buf_d      = 32'h0000_0000;
      word_idx_d = '0;
    end else if (discard) begin
      buf_d = 32'h0000_0000;
    end else if (byte_valid) begin
      if ((byte_lane == 2'd3) || byte_last) begin
        // Word registered straight into the write port; the buffer clears on
        // the same edge so a byte arriving during the write cycle starts fresh.
        we_d       = 1'b1;
        addr_d     = word_idx_q[IMEM_ADDR_WIDTH-1:0];
        wdata_d    = buf_merged;
        word_idx_d = word_idx_q + {{IMEM_ADDR_WIDTH{1'b0}}, 1'b1};
        buf_d      = 32'h0000_0000;
      end else begin
        buf_d = buf_merged;
      end
    end else begin
      buf_d = buf_q;
    end
  end

  // Packer state and write-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q      <= 32'h0000_0000;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      word_idx_q <= '0;
    end else begin
      buf_q      <= buf_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_idx_q <= word_idx_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_cnt   = word_idx_q;

endmodule

// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
//   Boot-time instruction RAM loader. While load_imem is high it takes the
//   UART byte stream framed as
//     4-byte little-endian count N, N payload bytes, 1 XOR checksum byte
//   packs the payload into 32-bit words, writes them into the instruction RAM
//   and holds the CPU in reset.
//   Ports:
//     clk, reset    system clock, synchronous active-high reset
//     load_imem     level, high while the loader owns the imem write port
//     rx_valid      one-cycle strobe from the UART receiver
//     rx_data       received byte
//     imem_we       instruction RAM write enable (one cycle per word)
//     imem_addr     word address
//     imem_wdata    write data, byte0 in bits 7:0
//     cpu_hold      holds the core in reset while loading
//     load_busy     high in HDR/DATA/CHK
//     load_done     sticky, load completed with a good checksum
//     load_error    sticky, load failed (oversize, bad checksum, abort)
//     load_words    words written in the current/last load
// -----------------------------------------------------------------------------
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_imem,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_hold,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_error,
  output logic [IMEM_ADDR_WIDTH:0]   load_words
);

  // Capacity compared one bit wider than the length so it never truncates.
  localparam logic [LEN_WIDTH:0] CAP_BYTES =
    (LEN_WIDTH+1)'(imem_capacity_bytes(IMEM_ADDR_WIDTH));

  logic [2:0]           state_q, state_d;
  logic                 load_imem_q;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]           chk_q, chk_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 load_busy_q, load_busy_d;
  logic                 load_done_q, load_done_d;
  logic                 load_error_q, load_error_d;

  logic [LEN_WIDTH-1:0] byte_cnt_inc;
  logic [LEN_WIDTH-1:0] len_hdr;
  logic                 len_over;

  logic                 pk_start;
  logic                 pk_discard;
  logic                 pk_valid;
  logic                 pk_last;

  // Header assembly: place the incoming byte into its little-endian slot and
  // evaluate the size check against the completed length.
  always_comb begin
    byte_cnt_inc = byte_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    len_hdr      = len_q | (LEN_WIDTH'(rx_data) << {byte_cnt_q[1:0], 3'b000});
    len_over     = ({1'b0, len_hdr} > CAP_BYTES);
  end

  // Loader FSM with checksum, header length and sticky status flags.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    chk_d        = chk_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    pk_start     = 1'b0;
    pk_discard   = 1'b0;
    pk_valid     = 1'b0;
    pk_last      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cpu_hold_d = 1'b0;
        // Only a rising edge starts a load, so a stuck-high level after a
        // finished load does not restart it.
        if (load_imem && !load_imem_q) begin
          state_d      = ST_HDR;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          len_d        = '0;
          byte_cnt_d   = '0;
          chk_d        = 8'h00;
          pk_start     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HDR: begin
        if (!load_imem) begin
          state_d      = ST_IDLE;
          cpu_hold_d   = 1'b0;
          load_error_d = 1'b1;
          pk_discard   = 1'b1;
        end else if (rx_valid) begin
          len_d = len_hdr;
          if (byte_cnt_q[1:0] == 2'(LOADER_HDR_BYTES - 32'd1)) begin
            byte_cnt_d = '0;
            if (len_hdr == '0) begin
              state_d = ST_CHK;
            end else if (len_over) begin
              state_d      = ST_ERR;
              load_error_d = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_inc;
          end
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_DATA: begin
        if (!load_imem) begin
          // Abort drops any partial word still sitting in the lane buffer.
          state_d      = ST_IDLE;
          cpu_hold_d   = 1'b0;
          load_error_d = 1'b1;
          pk_discard   = 1'b1;
        end else if (rx_valid) begin
          pk_valid   = 1'b1;
          chk_d      = chk_update(chk_q, rx_data);
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_inc == len_q) begin
            pk_last = 1'b1;
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_CHK: begin
        if (!load_imem) begin
          state_d      = ST_IDLE;
          cpu_hold_d   = 1'b0;
          load_error_d = 1'b1;
          pk_discard   = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
          end else begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
          end
        end else begin
          state_d = ST_CHK;
        end
      end

      ST_DONE, ST_ERR: begin
        // Core stays held until software/board drops load_imem.
        if (!load_imem) begin
          state_d    = ST_IDLE;
          cpu_hold_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cpu_hold_d = 1'b0;
      end
    endcase

    load_busy_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
  end

  // FSM, header, checksum and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      load_imem_q  <= 1'b0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      chk_q        <= 8'h00;
      cpu_hold_q   <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_imem_q  <= load_imem;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      chk_q        <= chk_d;
      cpu_hold_q   <= cpu_hold_d;
      load_busy_q  <= load_busy_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  imem_word_packer #(
    .IMEM_ADDR_WIDTH (IMEM_ADDR_WIDTH)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .start      (pk_start),
    .discard    (pk_discard),
    .byte_valid (pk_valid),
    .byte_lane  (byte_cnt_q[1:0]),
    .byte_data  (rx_data),
    .byte_last  (pk_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_cnt   (load_words)
  );

  assign cpu_hold   = cpu_hold_q;
  assign load_busy  = load_busy_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_uart_loader
//   Directed frames with hand-computed expected RAM writes. Expected writes
//   (address, data, cycle) are queued as bytes are sent; a monitor pops and
//   compares on every imem_we pulse. Status flags are checked between frames.
// -----------------------------------------------------------------------------
module tb_imem_uart_loader;

  logic        clk;
  logic        reset;
  logic        load_imem;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [10:0] load_words;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  cyc;
  int  n_cmp;
  int  n_bad;

  imem_uart_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_imem  (load_imem),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_error (load_error),
    .load_words (load_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we !== 1'b0) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_write: got addr=%0h data=%08h at cycle %0d, none expected",
                 imem_addr, imem_wdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data || cyc != mon_e.cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL write: got addr=%0h data=%08h cycle=%0d, expected addr=%0h data=%08h cycle=%0d",
                   imem_addr, imem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called one step after a rising edge; the byte is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Send a byte that completes a word; the write is due one cycle later.
  task automatic send_wr(input logic [7:0] b, input logic [9:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    send_byte(b);
  endtask

  task automatic send_hdr(input logic [31:0] n);
    logic [31:0] v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[8*i +: 8]);
    end
  endtask

  task automatic start_load(input string tag);
    load_imem = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold_on"},  64'(cpu_hold),   64'd1);
    check({tag, "_busy_on"},  64'(load_busy),  64'd1);
    check({tag, "_done_clr"}, 64'(load_done),  64'd0);
    check({tag, "_err_clr"},  64'(load_error), 64'd0);
  endtask

  task automatic end_load(input string tag);
    load_imem = 1'b0;
    #1;
    check({tag, "_hold_until_edge"}, 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_hold_off"}, 64'(cpu_hold),  64'd0);
    check({tag, "_busy_off"}, 64'(load_busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic [10:0] words);
    check({tag, "_done"},  64'(load_done),  64'(done));
    check({tag, "_error"}, 64'(load_error), 64'(err));
    check({tag, "_words"}, 64'(load_words), 64'(words));
    check({tag, "_busy"},  64'(load_busy),  64'd0);
    check({tag, "_hold"},  64'(cpu_hold),   64'd1);
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    load_imem = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    64'(imem_we),    64'd0);
    check("rst_addr",  64'(imem_addr),  64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_hold",  64'(cpu_hold),   64'd0);
    check("rst_busy",  64'(load_busy),  64'd0);
    check("rst_done",  64'(load_done),  64'd0);
    check("rst_error", 64'(load_error), 64'd0);
    check("rst_words", 64'(load_words), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Frame 1: N=8, payload 01..08, checksum 08, bytes back to back.
    start_load("f1");
    send_hdr(32'd8);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_wr(8'h04, 10'd0, 32'h04030201);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    send_wr(8'h08, 10'd1, 32'h08070605);
    send_byte(8'h08);
    check_status("f1", 1'b1, 1'b0, 11'd2);
    end_load("f1");

    // Frame 2: N=5, AA BB CC DD EE, checksum EE, partial last word zero-filled.
    start_load("f2");
    send_hdr(32'd5);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_wr(8'hDD, 10'd0, 32'hDDCCBBAA);
    send_wr(8'hEE, 10'd1, 32'h000000EE);
    send_byte(8'hEE);
    check_status("f2", 1'b1, 1'b0, 11'd2);
    end_load("f2");

    // Frame 3: as frame 1 but bad checksum 09, with idle gaps between bytes.
    start_load("f3");
    send_hdr(32'd8);
    send_byte(8'h01); @(posedge clk); #1;
    send_byte(8'h02); send_byte(8'h03);
    send_wr(8'h04, 10'd0, 32'h04030201);
    @(posedge clk); #1;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    send_wr(8'h08, 10'd1, 32'h08070605);
    send_byte(8'h09);
    check_status("f3", 1'b0, 1'b1, 11'd2);
    end_load("f3");

    // Frame 4: N=4097 exceeds 4096-byte capacity, trailing bytes ignored.
    start_load("f4");
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    check_status("f4", 1'b0, 1'b1, 11'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    end_load("f4");

    // Frame 5: N=0, checksum 00.
    start_load("f5");
    send_hdr(32'd0);
    send_byte(8'h00);
    check_status("f5", 1'b1, 1'b0, 11'd0);
    end_load("f5");

    // Frame 6: N=8, abort after 6 payload bytes; partial word dropped.
    start_load("f6");
    send_hdr(32'd8);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_wr(8'h04, 10'd0, 32'h04030201);
    send_byte(8'h05); send_byte(8'h06);
    load_imem = 1'b0;
    @(posedge clk);
    #1;
    check("f6_error", 64'(load_error), 64'd1);
    check("f6_done",  64'(load_done),  64'd0);
    check("f6_hold",  64'(cpu_hold),   64'd0);
    check("f6_busy",  64'(load_busy),  64'd0);
    check("f6_words", 64'(load_words), 64'd1);
    // Bytes in IDLE must not write anything.
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h07 + i));
    end
    repeat (3) @(posedge clk);
    #1;
    check("f6_idle_words",     64'(load_words),   64'd1);
    check("f6_pending_writes", 64'(exp_q.size()), 64'd0);
    check("f6_idle_hold",      64'(cpu_hold),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
